// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory responder and the CPU control unit:
//   - default data / address widths and array depth
//   - responder FSM state encoding (3-bit)
// -----------------------------------------------------------------------------
package mem_pkg;

    // Widths shared with the control unit / datapath
    localparam int MEM_DWIDTH      = 16;
    localparam int MEM_ADDR_WIDTH  = 12;
    localparam int MEM_DEPTH       = 4096;
    localparam int MEM_WAIT_CYCLES = 2;

    // State encoding
    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_WAIT   = 3'd1;
    localparam logic [2:0] ENC_ACCESS = 3'd2;
    localparam logic [2:0] ENC_RESP   = 3'd3;
    localparam logic [2:0] ENC_HOLD   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_WAIT   = ENC_WAIT,
        ST_ACCESS = ENC_ACCESS,
        ST_RESP   = ENC_RESP,
        ST_HOLD   = ENC_HOLD
    } mem_state_t;

endpackage

// File: rtl/sp_ram.sv
// -----------------------------------------------------------------------------
// sp_ram
// Synchronous single-port array, DWIDTH x DEPTH.
//   clk      : rising-edge clock
//   reset_n  : async active-low reset, clears the read register only
//   i_en     : access enable for this cycle
//   i_we     : 1 = write i_wdata to i_addr, 0 = read i_addr
//   i_addr   : word address (RAM_AW bits)
//   i_wdata  : write data
//   o_rdata  : registered read data; changes only on an enabled read
// The array contents are never reset.
// -----------------------------------------------------------------------------
module sp_ram #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4096,
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rdata;

    // Array write port: kept in its own reset-free block so it maps to RAM
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register holds its value across writes and idle cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the CPU memory request interface. Accepts one
// request at a time, inserts WAIT_CYCLES wait states, performs the access on
// an internal sp_ram and returns a one-cycle acknowledge.
//
// Handshake: i_ce is a level request sampled only in IDLE; i_we/i_addr/i_wdata
// are latched on that accept edge and ignored afterwards. o_ack pulses for one
// cycle when the request completes (o_err alongside it for an out-of-range
// address). If i_ce is still high after o_ack the responder parks in HOLD
// until i_ce drops, so a level-held request is serviced exactly once.
//
// Ports:
//   clk       : rising-edge clock
//   reset_n   : async active-low reset
//   i_ce      : request strobe (level)
//   i_we      : 1 = write, 0 = read
//   i_addr    : word address
//   i_wdata   : write data
//   o_rdata   : read data, valid from the ack cycle, held until next read
//   o_ack     : one-cycle completion pulse
//   o_err     : one-cycle out-of-range pulse, coincident with o_ack
//   o_busy    : high whenever the FSM is not in IDLE
//   o_state   : current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int DWIDTH      = MEM_DWIDTH,
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_ce,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0]     i_wdata,
    output logic [DWIDTH-1:0]     o_rdata,
    output logic                  o_ack,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [2:0]            o_state
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_t            r_state;
    logic [3:0]            r_wait_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DWIDTH-1:0]     r_wdata;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_busy;
    logic                  r_rd_zero;   // last completed read was out of range

    logic                  w_in_range;
    logic                  w_ram_en;
    logic [RAM_AW-1:0]     w_ram_addr;
    logic [DWIDTH-1:0]     w_ram_rdata;

    // Zero-extend before comparing so DEPTH == 2**ADDR_WIDTH works too
    assign w_in_range = (32'(r_addr) < DEPTH);

    // Out-of-range accesses never reach the array, so no aliasing can occur
    assign w_ram_en   = (r_state == ST_ACCESS) && w_in_range;
    assign w_ram_addr = r_addr[RAM_AW-1:0];

    sp_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_ram_en),
        .i_we    (r_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_zero  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_ce) begin
                        r_we    <= i_we;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_busy  <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= WAIT_INIT;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    // Loaded with WAIT_CYCLES-1 on entry: residency is WAIT_CYCLES
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    // Ack/err are registered here so they appear during RESP
                    r_ack   <= 1'b1;
                    r_err   <= !w_in_range;
                    if (!r_we) begin
                        r_rd_zero <= !w_in_range;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_ce) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!i_ce) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The array read register only moves on in-range reads; an out-of-range
    // read is presented as zero until the next completed read.
    assign o_rdata = r_rd_zero ? '0 : w_ram_rdata;
    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_busy  = r_busy;
    assign o_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 2048;
  localparam int WC    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_ce = 1'b0;
  logic          i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic [DW-1:0] o_rdata;
  logic          o_ack;
  logic          o_err;
  logic          o_busy;
  logic [2:0]    o_state;

  mem_responder #(
    .DWIDTH      (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WC)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_ce    (i_ce),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_ack   (o_ack),
    .o_err   (o_err),
    .o_busy  (o_busy),
    .o_state (o_state)
  );

  // scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          err_q[$];
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present a request for one accept edge and record the expectation
  task automatic start_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    logic oor;
    oor = (int'(addr) >= DEPTH);
    @(negedge clk);
    i_ce = 1'b1;
    i_we = we;
    i_addr = addr;
    i_wdata = wd;
    if (we) begin
      if (!oor) mem_m[int'(addr)] = wd;
    end else begin
      model_rdata = oor ? '0 : mem_m[int'(addr)];
    end
    exp_q.push_back(model_rdata);
    err_q.push_back(oor);
  endtask

  // monitor: cycle k = k-th cycle after the accept cycle; i_ce stays high
  // for `hold` cycles in total; chg alters the request fields during WAIT
  task automatic wait_ack(input int hold, input logic chg);
    int lat;
    int n_ack;
    logic [DW-1:0] e;
    logic ee;
    lat = 0;
    n_ack = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_ack) begin
        n_ack++;
        if (lat == 0) lat = k;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          ee = err_q.pop_front();
          chk("ack_rdata", o_rdata, e);
          chk("ack_err", o_err, ee);
        end else begin
          checks++;
          errors++;
          $error("FAIL extra_ack observed=1 expected=0 at cycle %0d", k);
        end
      end else begin
        chk("err_without_ack", o_err, 0);
      end
      if (lat > 0 && k > lat && k <= hold) begin
        chk("hold_state", o_state, ST_HOLD);
        chk("hold_busy", o_busy, 1);
      end
      if (chg && k == 1) begin
        i_addr = 12'h030;
        i_we = 1'b1;
        i_wdata = 16'hDEAD;
      end
      if (k == hold) i_ce = 1'b0;
      if (lat > 0 && k > lat && k > hold) begin
        chk("idle_after", o_state, ST_IDLE);
        chk("busy_after", o_busy, 0);
        break;
      end
    end
    chk("ack_latency", lat, WC + 2);
    chk("ack_count", n_ack, 1);
    chk("rdata_held", o_rdata, model_rdata);
  endtask

  task automatic xact(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    start_req(we, addr, wd);
    wait_ack(1, 1'b0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_state", o_state, ST_IDLE);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", o_busy, 0);
      chk("idle_ack", o_ack, 0);
      chk("idle_rdata", o_rdata, 0);
    end

    // basic write then read
    xact(1'b1, 12'h010, 16'h1234);
    xact(1'b0, 12'h010, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      chk("rdata_idle_hold", o_rdata, 16'h1234);
    end

    // level-held write: serviced once, parked in HOLD
    start_req(1'b1, 12'h040, 16'hA5A5);
    wait_ack(20, 1'b0);
    xact(1'b0, 12'h040, 16'h0000);

    // range boundary and out-of-range (0x900 would alias 0x100)
    xact(1'b1, 12'h100, 16'h0100);
    xact(1'b1, 12'h7FF, 16'h77FF);
    xact(1'b0, 12'h7FF, 16'h0000);
    xact(1'b0, 12'h800, 16'h0000);
    xact(1'b0, 12'h900, 16'h0000);
    xact(1'b1, 12'h900, 16'hBEEF);
    chk("oor_write_rdata", o_rdata, 0);
    xact(1'b0, 12'h100, 16'h0000);

    // request fields changed during WAIT are ignored
    xact(1'b1, 12'h020, 16'h2020);
    xact(1'b1, 12'h030, 16'h3030);
    start_req(1'b0, 12'h020, 16'h0000);
    wait_ack(1, 1'b1);
    xact(1'b0, 12'h030, 16'h0000);

    // random in-range write/read pairs
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(12'h200, 12'h7FF));
      d = DW'($urandom_range(0, 16'hFFFF));
      xact(1'b1, a, d);
      xact(1'b0, a, 16'h0000);
    end

    // reset during WAIT of a write abandons it
    xact(1'b1, 12'h005, 16'h00AA);
    xact(1'b0, 12'h005, 16'h0000);
    @(negedge clk);
    i_ce = 1'b1;
    i_we = 1'b1;
    i_addr = 12'h005;
    i_wdata = 16'h5555;
    @(negedge clk);
    i_ce = 1'b0;
    chk("pre_reset_state", o_state, ST_WAIT);
    reset_n = 1'b0;
    #1;
    chk("midrst_state", o_state, ST_IDLE);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ack", o_ack, 0);
    chk("midrst_err", o_err, 0);
    chk("midrst_rdata", o_rdata, 0);
    model_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_ack", o_ack, 0);
      chk("postrst_rdata", o_rdata, 0);
    end
    xact(1'b0, 12'h005, 16'h0000);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
